// File: rtl/cn_serial_if.sv
// Handshake bundle between the variable-node side and the check-node unit.
// Carries the VN->CN message stream and the CN->VN message stream.
interface cn_serial_if;
  logic [3:0] vn_data;
  logic       vn_valid;
  logic       vn_ready;
  logic [3:0] cn_data;
  logic [2:0] cn_idx;
  logic       cn_last;
  logic       cn_valid;
  logic       cn_ready;
  logic       parity;

  // Check-node unit side
  modport slave (
    input  vn_data, vn_valid, cn_ready,
    output vn_ready, cn_data, cn_idx, cn_last, cn_valid, parity
  );

  // Variable-node / consumer side
  modport master (
    output vn_data, vn_valid, cn_ready,
    input  vn_ready, cn_data, cn_idx, cn_last, cn_valid, parity
  );
endinterface

// File: rtl/cn_serial.sv
// Serial offset-min-sum check node. Collects DEG sign-magnitude messages,
// tracks min1/min2/min index and sign parity, then emits DEG extrinsic
// check-to-variable messages one per cycle along with the syndrome bit.
module cn_serial #(
  parameter int DEG    = 5,
  parameter int OFFSET = 0
) (
  input logic        clk,
  input logic        rst_n,
  cn_serial_if.slave bus
);

  localparam int                 CNT_W = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DEG - 1);
  localparam logic [1:0]         OFF   = 2'(OFFSET);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         min1, min2;
  logic [CNT_W-1:0]   min_idx;
  logic               sign_acc;
  logic [DEG-1:0]     sign_reg;

  logic               accept, emit_hs, at_last;
  logic [1:0]         in_mag;
  logic               in_sign;
  logic [1:0]         mag_sel, mag_out;
  logic               sign_out;

  // Offset correction on a 2-bit magnitude, clamped at zero.
  function automatic logic [1:0] sat_sub(input logic [1:0] m);
    sat_sub = (m > OFF) ? (m - OFF) : 2'd0;
  endfunction

  // Zero magnitude is always +0 so a "-0" input never flips the parity.
  assign in_mag  = bus.vn_data[1:0];
  assign in_sign = bus.vn_data[2] & (in_mag != 2'd0);
  assign at_last = (cnt == LAST);

  // Extrinsic magnitude: the edge holding the minimum sees the second minimum.
  assign mag_sel  = (cnt == min_idx) ? min2 : min1;
  assign mag_out  = sat_sub(mag_sel);
  assign sign_out = sign_acc ^ sign_reg[cnt];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/output drive.
  always_comb begin
    state_nxt    = state;
    bus.vn_ready = 1'b0;
    bus.cn_valid = 1'b0;
    bus.cn_data  = 4'b0000;
    bus.cn_idx   = 3'd0;
    bus.cn_last  = 1'b0;
    bus.parity   = 1'b0;
    accept       = 1'b0;
    emit_hs      = 1'b0;
    case (state)
      COLLECT: begin
        bus.vn_ready = 1'b1;
        accept       = bus.vn_valid;
        if (accept && at_last) state_nxt = EMIT;
      end
      EMIT: begin
        bus.cn_valid = 1'b1;
        bus.cn_idx   = 3'(cnt);
        bus.cn_last  = at_last;
        bus.parity   = sign_acc;
        bus.cn_data  = (mag_out == 2'd0) ? 4'b0000 : {1'b0, sign_out, mag_out};
        emit_hs      = bus.cn_ready;
        if (emit_hs && at_last) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Accumulators: min tracking and signs while collecting, counter walk and
  // frame clear while emitting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      min1     <= 2'd3;
      min2     <= 2'd3;
      min_idx  <= '0;
      sign_acc <= 1'b0;
      sign_reg <= '0;
    end else if (accept) begin
      sign_reg[cnt] <= in_sign;
      sign_acc      <= sign_acc ^ in_sign;
      if (in_mag < min1) begin
        min2    <= min1;
        min1    <= in_mag;
        min_idx <= cnt;
      end else if (in_mag < min2) begin
        min2 <= in_mag;
      end
      cnt <= at_last ? '0 : cnt + 1'b1;
    end else if (emit_hs) begin
      if (at_last) begin
        cnt      <= '0;
        min1     <= 2'd3;
        min2     <= 2'd3;
        min_idx  <= '0;
        sign_acc <= 1'b0;
        sign_reg <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cn_serial.sv
// Scoreboard bench for cn_serial: two instances (OFFSET 0 and 1), expected
// check-to-variable messages queued when a frame is driven, popped on each
// output handshake.
module tb_cn_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cn_serial_if a();
  cn_serial_if b();

  cn_serial #(.DEG(5), .OFFSET(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  cn_serial #(.DEG(5), .OFFSET(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] e0, e1;
  int acc0 = 0, hs0 = 0, hs1 = 0;
  logic        rec_en = 1'b0;
  int          rec_n = 0;
  logic [29:0] rec_bits = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Spec-level model of one frame; entry = {parity, last, idx[2:0], data[3:0]}.
  function automatic void push_exp(input int sel, input logic [19:0] f, input int off);
    logic [1:0] mn1, mn2, m, mo;
    int mi;
    logic acc, s;
    logic [4:0] sg;
    logic [3:0] d;
    mn1 = 2'd3; mn2 = 2'd3; mi = 0; acc = 1'b0; sg = '0;
    for (int k = 0; k < 5; k++) begin
      d = f[4*k +: 4];
      m = d[1:0];
      s = d[2] && (m != 2'd0);
      sg[k] = s;
      acc = acc ^ s;
      if (m < mn1) begin mn2 = mn1; mn1 = m; mi = k; end
      else if (m < mn2) mn2 = m;
    end
    for (int k = 0; k < 5; k++) begin
      mo = (k == mi) ? mn2 : mn1;
      mo = (int'(mo) > off) ? 2'(int'(mo) - off) : 2'd0;
      d = (mo == 2'd0) ? 4'b0000 : {1'b0, acc ^ sg[k], mo};
      if (sel == 0) q0.push_back({acc, (k == 4), 3'(k), d});
      else          q1.push_back({acc, (k == 4), 3'(k), d});
    end
  endfunction

  // Output monitors and input-accept counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && a.vn_valid && a.vn_ready) acc0++;
    if (rec_en && rec_n < 30) begin
      rec_bits[rec_n] = a.vn_ready;
      rec_n++;
    end
    if (rst_n && a.cn_valid && a.cn_ready) begin
      hs0++;
      if (q0.size() == 0) check("u0_unexpected_out", 32'(a.cn_idx), 32'hFF);
      else begin
        e0 = q0.pop_front();
        check("u0_data",   32'(a.cn_data), 32'(e0[3:0]));
        check("u0_idx",    32'(a.cn_idx),  32'(e0[6:4]));
        check("u0_last",   32'(a.cn_last), 32'(e0[7]));
        check("u0_parity", 32'(a.parity),  32'(e0[8]));
      end
    end
    if (rst_n && b.cn_valid && b.cn_ready) begin
      hs1++;
      if (q1.size() == 0) check("u1_unexpected_out", 32'(b.cn_idx), 32'hFF);
      else begin
        e1 = q1.pop_front();
        check("u1_data",   32'(b.cn_data), 32'(e1[3:0]));
        check("u1_idx",    32'(b.cn_idx),  32'(e1[6:4]));
        check("u1_last",   32'(b.cn_last), 32'(e1[7]));
        check("u1_parity", 32'(b.parity),  32'(e1[8]));
      end
    end
  end

  // Drive one frame (element 0 in bits 3:0) into instance sel.
  task automatic send(input int sel, input logic [19:0] f);
    logic ok;
    push_exp(sel, f, (sel == 0) ? 0 : 1);
    for (int i = 0; i < 5; i++) begin
      if (sel == 0) begin a.vn_data = f[4*i +: 4]; a.vn_valid = 1'b1; end
      else          begin b.vn_data = f[4*i +: 4]; b.vn_valid = 1'b1; end
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        ok = (sel == 0) ? a.vn_ready : b.vn_ready;
      end
      if (!ok) check("vn_ready_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    if (sel == 0) a.vn_valid = 1'b0;
    else          b.vn_valid = 1'b0;
  endtask

  // Wait for the scoreboard of instance sel to drain, bounded.
  task automatic wait_empty(input int sel);
    for (int c = 0; c < 200; c++) begin
      if (((sel == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if (((sel == 0) ? q0.size() : q1.size()) != 0)
      check("drain_timeout", 32'((sel == 0) ? q0.size() : q1.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_hs;
    logic [29:0] exp_pat;
    a.vn_data = 4'h0; a.vn_valid = 1'b0; a.cn_ready = 1'b0;
    b.vn_data = 4'h0; b.vn_valid = 1'b0; b.cn_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vn_ready", 32'(a.vn_ready), 32'd1);
    check("rst_cn_valid", 32'(a.cn_valid), 32'd0);
    check("rst_cn_last",  32'(a.cn_last),  32'd0);
    check("rst_cn_idx",   32'(a.cn_idx),   32'd0);
    check("rst_cn_data",  32'(a.cn_data),  32'd0);
    check("rst_parity",   32'(a.parity),   32'd0);
    rst_n = 1'b1;

    // Basic min-sum frame; first output right after the 5th accept.
    a.cn_ready = 1'b1;
    send(0, {4'h1, 4'h6, 4'h3, 4'h5, 4'h2});
    check("latency_cn_valid", 32'(a.cn_valid), 32'd1);
    check("emit_vn_ready",    32'(a.vn_ready), 32'd0);
    wait_empty(0);

    // -0 treated as +0.
    send(0, {4'h1, 4'h2, 4'h7, 4'h3, 4'h4});
    wait_empty(0);

    // Offset 1, bit3 ignored.
    b.cn_ready = 1'b1;
    send(1, {4'h3, 4'h3, 4'h3, 4'h3, 4'hB});
    wait_empty(1);
    check("u1_handshakes", 32'(hs1), 32'd5);

    // Backpressure at k=2 with vn_valid pulses that must be ignored.
    a.cn_ready = 1'b0;
    send(0, {4'h1, 4'h6, 4'h3, 4'h5, 4'h2});
    a.cn_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a.cn_ready = 1'b0;
    base_acc = acc0;
    repeat (3) begin
      a.vn_valid = 1'b1; a.vn_data = 4'h3;
      @(negedge clk);
      check("bp_idx",      32'(a.cn_idx),   32'd2);
      check("bp_data",     32'(a.cn_data),  32'h1);
      check("bp_valid",    32'(a.cn_valid), 32'd1);
      check("bp_vn_ready", 32'(a.vn_ready), 32'd0);
      @(posedge clk); #1;
      a.vn_valid = 1'b0;
    end
    check("bp_no_accept", 32'(acc0 - base_acc), 32'd0);
    a.cn_ready = 1'b1;
    wait_empty(0);

    // Reset in the middle of emission at k=3.
    send(0, {4'h7, 4'h6, 4'h5, 4'h4, 4'h3});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_idx", 32'(a.cn_idx), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_cn_valid", 32'(a.cn_valid), 32'd0);
    check("mid_rst_vn_ready", 32'(a.vn_ready), 32'd1);
    check("mid_rst_cn_data",  32'(a.cn_data),  32'd0);
    check("mid_rst_discard",  32'(q0.size()),  32'd2);
    q0.delete();
    send(0, {4'h1, 4'h1, 4'h1, 4'h1, 4'h1});
    wait_empty(0);

    // Back-to-back frames with vn_valid and cn_ready held high.
    base_acc = acc0;
    base_hs  = hs0;
    rec_en   = 1'b1;
    for (int fr = 0; fr < 3; fr++) send(0, 20'($urandom));
    wait_empty(0);
    rec_en = 1'b0;
    for (int i = 0; i < 30; i++) exp_pat[i] = ((i / 5) % 2) == 0;
    check("b2b_accepts",    32'(acc0 - base_acc), 32'd15);
    check("b2b_handshakes", 32'(hs0 - base_hs),   32'd15);
    check("b2b_ready_pat",  32'(rec_bits),        32'(exp_pat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
